// File: rtl/tdc_chain_decoder_if.sv
// Bundle carrying the TDC decoder's control inputs, the raw chain word and the
// decoded result. Ports: arm, hit, chain_in (toward decoder); valid, fine_out,
// coarse_out, overflow, busy, bubble (from decoder).
interface tdc_chain_decoder_if #(
  parameter int CHAIN_LEN = 200,
  parameter int FINE_W    = 8,
  parameter int COARSE_W  = 16
);
  logic                 arm;
  logic                 hit;
  logic [CHAIN_LEN-1:0] chain_in;
  logic                 valid;
  logic [FINE_W-1:0]    fine_out;
  logic [COARSE_W-1:0]  coarse_out;
  logic                 overflow;
  logic                 busy;
  logic                 bubble;

  // master: the capture/trigger side that feeds the decoder
  modport master (
    output arm, hit, chain_in,
    input  valid, fine_out, coarse_out, overflow, busy, bubble
  );

  // slave: the decoder itself
  modport slave (
    input  arm, hit, chain_in,
    output valid, fine_out, coarse_out, overflow, busy, bubble
  );
endinterface

// File: rtl/tdc_chain_decoder.sv
// Carry-chain TDC back end: thermometer word -> fine code via a bubble-tolerant
// 3-stage popcount, paired with a coarse count latched at the hit.
// Ports: clk, rst (sync, active-high), bus (slave side of tdc_chain_decoder_if).
// Optional macro TDC_BUBBLE_CHECK_EN builds thermometer-order violation detection.
module tdc_chain_decoder #(
  parameter int CHAIN_LEN = 200,
  parameter int FINE_W    = 8,
  parameter int COARSE_W  = 16,
  parameter int SEG       = 8
) (
  input logic                clk,
  input logic                rst,
  tdc_chain_decoder_if.slave bus
);

  localparam int NSEG   = (CHAIN_LEN - 1 + SEG - 1) / SEG;
  localparam int PAD_W  = NSEG * SEG;
  localparam int SEGC_W = $clog2(SEG + 1);
  localparam int ONES_W = $clog2(CHAIN_LEN);

  typedef enum logic {IDLE, ARMED} state_t;

  state_t state, state_nxt;
  logic   capture;

  logic [COARSE_W-1:0] coarse_cnt;

  logic                 cap_vld;
  logic [CHAIN_LEN-1:0] cap_chain;
  logic [COARSE_W-1:0]  cap_coarse;

  logic [PAD_W-1:0]  seg_bits;
  logic [SEGC_W-1:0] seg_cnt [NSEG];

  logic                s1_vld;
  logic [SEGC_W-1:0]   s1_cnt [NSEG];
  logic                s1_msb;
  logic [COARSE_W-1:0] s1_coarse;

  logic [ONES_W-1:0]   ones_sum;
  logic                s2_vld;
  logic [ONES_W-1:0]   s2_ones;
  logic                s2_msb;
  logic [COARSE_W-1:0] s2_coarse;

  logic                valid_q;
  logic [FINE_W-1:0]   fine_q;
  logic [COARSE_W-1:0] coarse_q;
  logic                ovf_q;

  // Free-running coarse time base; wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) coarse_cnt <= '0;
    else     coarse_cnt <= coarse_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Hits only count while armed; arm alongside a hit keeps us armed so
  // back-to-back hits can be taken without a gap.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.arm) state_nxt = ARMED;
      end
      ARMED: begin
        if (bus.hit) begin
          capture   = 1'b1;
          state_nxt = bus.arm ? ARMED : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Valid bits are reset so a reset flushes any decode in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_vld <= 1'b0;
      s1_vld  <= 1'b0;
      s2_vld  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      cap_vld <= capture;
      s1_vld  <= cap_vld;
      s2_vld  <= s1_vld;
      valid_q <= s2_vld;
    end
  end

  // Data path registers carry no reset; only their valid bits matter.
  always_ff @(posedge clk) begin
    if (capture) begin
      cap_chain  <= bus.chain_in;
      cap_coarse <= coarse_cnt;
    end
    s1_cnt    <= seg_cnt;
    s1_msb    <= cap_chain[CHAIN_LEN-1];
    s1_coarse <= cap_coarse;
    s2_ones   <= ones_sum;
    s2_msb    <= s1_msb;
    s2_coarse <= s1_coarse;
  end

  // Counting ones instead of locating the transition makes the code tolerant
  // to bubbles. The MSB is handled separately as the overflow indicator.
  assign seg_bits = PAD_W'(cap_chain[CHAIN_LEN-2:0]);

  always_comb begin
    for (int s = 0; s < NSEG; s++) begin
      seg_cnt[s] = '0;
      for (int b = 0; b < SEG; b++) begin
        seg_cnt[s] = seg_cnt[s] + SEGC_W'(seg_bits[s*SEG+b]);
      end
    end
  end

  always_comb begin
    ones_sum = '0;
    for (int s = 0; s < NSEG; s++) begin
      ones_sum = ones_sum + ONES_W'(s1_cnt[s]);
    end
  end

  // Output registers hold until the next result.
  always_ff @(posedge clk) begin
    if (rst) begin
      fine_q   <= '0;
      coarse_q <= '0;
      ovf_q    <= 1'b0;
    end else if (s2_vld) begin
      fine_q   <= s2_msb ? FINE_W'(CHAIN_LEN - 1)
                         : FINE_W'(CHAIN_LEN - 1) - FINE_W'(s2_ones);
      coarse_q <= s2_coarse;
      ovf_q    <= s2_msb;
    end
  end

  assign bus.valid      = valid_q;
  assign bus.fine_out   = fine_q;
  assign bus.coarse_out = coarse_q;
  assign bus.overflow   = ovf_q;
  assign bus.busy       = (state == ARMED) | cap_vld | s1_vld | s2_vld;

`ifdef TDC_BUBBLE_CHECK_EN
  logic        bub_any;
  logic        s1_bub;
  logic        s2_bub;
  logic        bub_q;
  logic [15:0] bub_cnt;

  // A one sitting directly below a zero breaks thermometer order.
  always_comb begin
    bub_any = 1'b0;
    for (int i = 0; i <= CHAIN_LEN - 3; i++) begin
      if (cap_chain[i] && !cap_chain[i+1]) bub_any = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    s1_bub <= bub_any;
    s2_bub <= s1_bub;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bub_q   <= 1'b0;
      bub_cnt <= '0;
    end else if (s2_vld) begin
      bub_q <= s2_bub;
      if (s2_bub && bub_cnt != 16'hFFFF) bub_cnt <= bub_cnt + 16'd1;
    end
  end

  assign bus.bubble = valid_q & bub_q;
`else
  assign bus.bubble = 1'b0;
`endif

endmodule

// File: doc/tdc_chain_decoder.md
Name: tdc_chain_decoder

Overview:
Back-end reader for the carry-chain TDC. Takes the raw thermometer word captured by the chain on the stop edge and converts it to a binary fine-time code, using a bubble-tolerant pipelined ones-count. Pairs the fine code with a free-running coarse counter value latched at the hit. Sits in the clk domain, between the chain capture register and the readout FIFO/trigger logic.

Parameters:
CHAIN_LEN, 200, carry-chain length in bits; must match the chain instance.
FINE_W, 8, fine code width; must be ≥ clog2(CHAIN_LEN).
COARSE_W, 16, coarse counter width.
SEG, 8, segment width of the stage-1 partial popcounts.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
arm  in  1  single-cycle pulse; arms the decoder for one hit
hit  in  1  single-cycle pulse, already synchronised to clk; chain_in is stable in this cycle
chain_in  in  CHAIN_LEN  raw captured chain word
valid  out  1  one-cycle strobe; outputs below are valid
fine_out  out  FINE_W  fine delay code, 0..CHAIN_LEN-1
coarse_out  out  COARSE_W  coarse count latched at the hit
overflow  out  1  the start edge traversed the whole chain
busy  out  1  armed, or a decode is in flight
bubble  out  1  non-thermometer pattern detected (see Optional Feature)

Behaviour:
- Reset: all outputs 0; FSM goes to IDLE; pipeline valid bits cleared; coarse counter set to 0.
- Coarse counter increments every clk and wraps at 2^COARSE_W-1 → 0.
- FSM states: IDLE, ARMED.
  - IDLE + arm → ARMED. A hit in IDLE is ignored. arm and hit in the same IDLE cycle: arm wins and the hit is dropped.
  - ARMED + hit → capture, then go to IDLE. If arm is also high in that cycle, capture and stay in ARMED (allows back-to-back hits).
  - arm in ARMED with no hit: no effect.
- Capture at edge N: register chain_in and the current coarse count.
- Stage 1 (edge N+1): split bits [CHAIN_LEN-2:0] into ceil((CHAIN_LEN-1)/SEG) segments, zero-padding the top segment. Register each segment's ones-count. Register MSB = chain[CHAIN_LEN-1].
- Stage 2 (edge N+2): register ones = sum of the segment counts.
- Stage 3 (edge N+3):
  - fine_out = CHAIN_LEN-1-ones.
  - If the MSB is 1: overflow = 1 and fine_out = CHAIN_LEN-1, saturated regardless of ones.
  - coarse_out is the value captured at edge N.
  - valid is high for exactly one cycle.
- Latency: hit sampled at edge N → valid high in the cycle after edge N+3.
- The pipeline accepts one capture per cycle. Output registers hold their values until the next valid.
- busy = (state == ARMED) OR any pipeline stage valid.
- Reset mid-decode flushes the pipeline; no valid is produced for in-flight captures.
- Coarse wrap between capture and output has no effect; the latched value is used.

Optional Feature:
Macro TDC_BUBBLE_CHECK_EN.
- Defined:
  - Stage 1 also flags any index i in [0, CHAIN_LEN-3] with chain[i]=1 and chain[i+1]=0, i.e. a one below a zero, which breaks the thermometer order.
  - The flag is piped alongside the data and drives bubble, qualified by valid.
  - A 16-bit saturating bubble counter is kept internally. It is reset by rst and has no readout requirement.
- Undefined: bubble is tied to 0, and no detection logic or counter is built.
- fine_out is identical in both builds.

Test Plan:
- rst, arm, hit with chain_in = bit199=0, bits[198:0] all 1 → valid 4 cycles later, fine_out=0, overflow=0.
- arm; hit when the coarse counter = 0x1234, with bits[49:0]=0, bits[198:50]=1, MSB=0 → fine_out=50, coarse_out=0x1234.
- arm; hit with chain_in = 1 followed by 199 zeros → overflow=1, fine_out=199.
- hit without arm, and arm+hit together in IDLE → no valid. A following hit while ARMED → exactly one valid.
- arm held with hits on 3 consecutive cycles (fine 10, 20, 30) → 3 consecutive valids, in order, with correct values. rst asserted during the second decode → no further valid.
- TDC_BUBBLE_CHECK_EN: bits[49:0]=0 except bit10=1, bits[198:50]=1 → fine_out=49, bubble=1. The same pattern without the macro → bubble=0, fine_out=49.
